// File: rtl/lfsr_descrambler_if.sv
// Stream/seed bundle for lfsr_descrambler.
// Optional word_count appears with LFSR_DESCRAMBLER_WORD_COUNT_EN.
interface lfsr_descrambler_if #(
    parameter int WIDTH    = 64,
    parameter int LFSR_LEN = 64
);
    logic                seed_load;
    logic [LFSR_LEN-1:0] seed;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                locked;
`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
    logic [31:0]         word_count;
`endif

    modport master (
        output seed_load, seed, in_valid, in_data, out_ready,
`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
        input  word_count,
`endif
        input  in_ready, out_valid, out_data, locked
    );

    modport slave (
        input  seed_load, seed, in_valid, in_data, out_ready,
`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
        output word_count,
`endif
        output in_ready, out_valid, out_data, locked
    );
endinterface

// File: rtl/lfsr_descrambler.sv
// Additive Galois-LFSR descrambler, one registered output stage.
// LFSR_DESCRAMBLER_WORD_COUNT_EN adds a 32-bit accepted-word counter.
module lfsr_descrambler #(
    parameter int                  WIDTH    = 64,
    parameter int                  LFSR_LEN = 64,
    parameter logic [LFSR_LEN-1:0] TAPS     = 64'hD800_0000_0000_0000,
    parameter int                  delay    = 50
) (
    input logic                  clk,
    input logic                  reset,
    lfsr_descrambler_if.slave    bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t              fsm;
    logic                locked_q;
    logic [LFSR_LEN-1:0] lfsr;
    logic [LFSR_LEN-1:0] lfsr_next;
    logic [LFSR_LEN-1:0] seed_fix;
    logic [WIDTH-1:0]    ks;
    logic [WIDTH-1:0]    xored;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic                ready;
    logic                accept;

    // All WIDTH Galois steps unrolled into one cycle
    always_comb begin
        logic [LFSR_LEN-1:0] s;
        s  = lfsr;
        ks = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ks[i] = s[0];
            s     = (s >> 1) ^ (s[0] ? TAPS : '0);
        end
        lfsr_next = s;
    end

    // delay only annotates the XOR stage in simulation; logic is the same
    if (delay > 0) begin : g_xor_dly
        assign xored = bus.in_data ^ ks;
    end else begin : g_xor
        assign xored = bus.in_data ^ ks;
    end

    // All-zero seed would lock the LFSR up
    assign seed_fix = (bus.seed == '0)
                    ? {{(LFSR_LEN-1){1'b0}}, 1'b1}
                    : bus.seed;

    assign ready  = locked_q & ~bus.seed_load
                  & (~out_valid_q | bus.out_ready);
    assign accept = bus.in_valid & ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm         <= IDLE;
            locked_q    <= 1'b0;
            lfsr        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (fsm)
                IDLE: if (bus.seed_load) begin
                    fsm      <= RUN;
                    locked_q <= 1'b1;
                end
                RUN: begin
                    fsm      <= RUN;
                    locked_q <= 1'b1;
                end
                default: begin
                    fsm      <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase

            if (bus.seed_load)
                lfsr <= seed_fix;
            else if (accept)
                lfsr <= lfsr_next;

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= xored;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (bus.seed_load)
            cnt <= '0;
        else if (accept)
            cnt <= cnt + 32'd1;
    end

    assign bus.word_count = cnt;
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_lfsr_descrambler.sv
// Bench for lfsr_descrambler: vector table, corner sequences,
// and randomized traffic against a keystream reference model.
module tb_lfsr_descrambler;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    lfsr_descrambler_if #(.WIDTH(8), .LFSR_LEN(8)) dif ();

    lfsr_descrambler #(
        .WIDTH(8), .LFSR_LEN(8), .TAPS(8'hB8), .delay(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(dif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Spec keystream: k[i]=s[0], s=(s>>1)^(s[0]?TAPS:0), eight times
    function automatic logic [15:0] keyword(input logic [7:0] s0);
        logic [7:0] s;
        logic [7:0] k;
        s = s0;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = s[0];
            s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        end
        return {s, k};
    endfunction

    task automatic do_seed(input logic [7:0] sd);
        @(negedge clk);
        dif.seed_load = 1'b1;
        dif.seed      = sd;
        dif.in_valid  = 1'b1;
        #1 chk("seed_ready", 32'(dif.in_ready), 32'd0);
        @(negedge clk);
        dif.seed_load = 1'b0;
        dif.in_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ms, mod, d, sd;
        logic [15:0] kw;
        logic        mov, sl, iv, ordy, erdy, acc;
        logic [31:0] mcnt;

        vecs[0] = '{8'h01, 8'h71, 8'hA4, 8'h00, 8'h00};
        vecs[1] = '{8'h00, 8'h71, 8'hA4, 8'h00, 8'h00};
        vecs[2] = '{8'h01, 8'hFF, 8'hFF, 8'h8E, 8'h5B};
        vecs[3] = '{8'h01, 8'h00, 8'h00, 8'h71, 8'hA4};

        dif.seed_load = 0; dif.seed = 0; dif.in_valid = 0;
        dif.in_data = 0; dif.out_ready = 1;

        // Unseeded: nothing accepted
        @(negedge clk);
        chk("rst_out_data", 32'(dif.out_data), 32'd0);
        reset = 1'b1;
        dif.in_valid = 1'b1;
        dif.in_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("unseed_ready", 32'(dif.in_ready), 32'd0);
            chk("unseed_locked", 32'(dif.locked), 32'd0);
            chk("unseed_valid", 32'(dif.out_valid), 32'd0);
            @(negedge clk);
        end
        dif.in_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_seed(vecs[v].seed);
            chk("vec_locked", 32'(dif.locked), 32'd1);
            dif.in_valid = 1'b1;
            dif.in_data  = vecs[v].a;
            @(negedge clk);
            chk("vec_valid_a", 32'(dif.out_valid), 32'd1);
            chk("vec_data_a", 32'(dif.out_data), 32'(vecs[v].exp_a));
            dif.in_data = vecs[v].b;
            @(negedge clk);
            chk("vec_data_b", 32'(dif.out_data), 32'(vecs[v].exp_b));
            dif.in_valid = 1'b0;
            @(negedge clk);
            chk("vec_drain", 32'(dif.out_valid), 32'd0);
        end

        // Backpressure holds data and stalls the LFSR
        do_seed(8'h01);
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_data   = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 32'(dif.out_valid), 32'd1);
            chk("bp_data", 32'(dif.out_data), 32'h8E);
            chk("bp_ready", 32'(dif.in_ready), 32'd0);
            @(negedge clk);
        end
        dif.out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(dif.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_data2", 32'(dif.out_data), 32'h5B);
        dif.in_valid = 1'b0;
        @(negedge clk);

        // Reseed mid-stream restarts the keystream
        do_seed(8'h01);
        dif.in_valid = 1'b1;
        dif.in_data  = 8'h71;
        @(negedge clk);
        chk("reseed_first", 32'(dif.out_data), 32'h00);
        dif.in_valid = 1'b0;
        do_seed(8'h01);
        dif.in_valid = 1'b1;
        dif.in_data  = 8'h71;
        @(negedge clk);
        chk("reseed_again", 32'(dif.out_data), 32'h00);
        dif.in_valid = 1'b0;

        // Asynchronous reset with a pending word
        dif.out_ready = 1'b0;
        do_seed(8'h01);
        dif.in_valid = 1'b1;
        dif.in_data  = 8'h33;
        @(negedge clk);
        dif.in_valid = 1'b0;
        chk("ar_pending", 32'(dif.out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(dif.out_valid), 32'd0);
        chk("ar_locked", 32'(dif.locked), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dif.out_ready = 1'b1;

`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
        do_seed(8'h01);
        chk("wc_seed", dif.word_count, 32'd0);
        dif.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        dif.in_valid = 1'b0;
        chk("wc_three", dif.word_count, 32'd3);
        do_seed(8'h07);
        chk("wc_clear", dif.word_count, 32'd0);
`endif

        // Randomized traffic against the model
        @(negedge clk);
        sd = 8'($urandom);
        do_seed(sd);
        ms   = (sd == 8'h00) ? 8'h01 : sd;
        mov  = 1'b0;
        mod  = 8'h00;
        mcnt = 32'd0;
        for (int c = 0; c < 400; c++) begin
            sl   = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            d    = 8'($urandom);
            sd   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            dif.seed_load = sl;
            dif.seed      = sd;
            dif.in_valid  = iv;
            dif.in_data   = d;
            dif.out_ready = ordy;
            erdy = !sl && (!mov || ordy);
            #1 chk("rnd_ready", 32'(dif.in_ready), 32'(erdy));
            acc = iv && erdy;
            kw  = keyword(ms);
            if (sl)
                ms = (sd == 8'h00) ? 8'h01 : sd;
            else if (acc)
                ms = kw[15:8];
            if (acc) begin
                mov = 1'b1;
                mod = d ^ kw[7:0];
            end else if (ordy) begin
                mov = 1'b0;
            end
            if (sl)
                mcnt = 32'd0;
            else if (acc)
                mcnt = mcnt + 32'd1;
            @(negedge clk);
            chk("rnd_valid", 32'(dif.out_valid), 32'(mov));
            if (mov)
                chk("rnd_data", 32'(dif.out_data), 32'(mod));
`ifdef LFSR_DESCRAMBLER_WORD_COUNT_EN
            chk("rnd_count", dif.word_count, mcnt);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
